// File: rtl/threshold_monitor.sv
// Registered threshold comparator with signed/unsigned mode, hysteresis band and a
// persistence filter that debounces the "above" state with rise/fall events and sticky flags.
module threshold_monitor #(
   parameter int WIDTH   = 16,
   parameter bit SIGNED  = 1'b0,
   parameter int PERSIST = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in,
   input  logic [WIDTH-1:0] thresh,
   input  logic [WIDTH-1:0] hyst,
   input  logic             clr,
   output logic             greater,
   output logic             lesser,
   output logic             equal,
   output logic             above,
   output logic             rise_evt,
   output logic             fall_evt,
   output logic             rise_seen,
   output logic             fall_seen
);
   localparam int XW = WIDTH + 2;
   localparam int CW = $clog2(PERSIST + 1);
   localparam logic [CW-1:0] P_LAST = CW'(PERSIST);

   typedef enum logic [1:0] {LOW, PEND_HIGH, HIGH, PEND_LOW} state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_greater, r_lesser, r_equal, r_above;
   logic          r_rise_evt, r_fall_evt, r_rise_seen, r_fall_seen;

   logic          w_sx_in, w_sx_th;
   logic signed [XW-1:0] w_in_x, w_th_x, w_hy_x, w_upper, w_lower;
   logic          w_hi_q, w_lo_q, w_gt, w_lt, w_eq;
   logic [CW-1:0] w_cnt_inc;

   // Two guard bits keep thresh +/- hyst exact, so every compare is a plain signed one.
   assign w_sx_in   = SIGNED ? in[WIDTH-1] : 1'b0;
   assign w_sx_th   = SIGNED ? thresh[WIDTH-1] : 1'b0;
   assign w_in_x    = {{2{w_sx_in}}, in};
   assign w_th_x    = {{2{w_sx_th}}, thresh};
   assign w_hy_x    = {2'b00, hyst};
   assign w_upper   = w_th_x + w_hy_x;
   assign w_lower   = w_th_x - w_hy_x;
   assign w_hi_q    = w_in_x > w_upper;
   assign w_lo_q    = w_in_x < w_lower;
   assign w_gt      = w_in_x > w_th_x;
   assign w_lt      = w_in_x < w_th_x;
   assign w_eq      = w_in_x == w_th_x;
   assign w_cnt_inc = r_cnt + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= LOW;
         r_cnt       <= '0;
         r_greater   <= 1'b0;
         r_lesser    <= 1'b0;
         r_equal     <= 1'b0;
         r_above     <= 1'b0;
         r_rise_evt  <= 1'b0;
         r_fall_evt  <= 1'b0;
         r_rise_seen <= 1'b0;
         r_fall_seen <= 1'b0;
      end else begin
         r_rise_evt <= 1'b0;
         r_fall_evt <= 1'b0;
         // A pulse being presented or being generated this edge beats a concurrent clr.
         if (clr && !r_rise_evt) r_rise_seen <= 1'b0;
         if (clr && !r_fall_evt) r_fall_seen <= 1'b0;
         if (in_valid) begin
            r_greater <= w_gt;
            r_lesser  <= w_lt;
            r_equal   <= w_eq;
            case (r_state)
               LOW: if (w_hi_q) begin
                  if (PERSIST == 1) begin
                     r_state     <= HIGH;
                     r_above     <= 1'b1;
                     r_rise_evt  <= 1'b1;
                     r_rise_seen <= 1'b1;
                  end else begin
                     r_state <= PEND_HIGH;
                     r_cnt   <= CW'(1);
                  end
               end
               PEND_HIGH: if (!w_hi_q) begin
                  r_state <= LOW;
                  r_cnt   <= '0;
               end else if (w_cnt_inc == P_LAST) begin
                  r_state     <= HIGH;
                  r_cnt       <= '0;
                  r_above     <= 1'b1;
                  r_rise_evt  <= 1'b1;
                  r_rise_seen <= 1'b1;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
               HIGH: if (w_lo_q) begin
                  if (PERSIST == 1) begin
                     r_state     <= LOW;
                     r_above     <= 1'b0;
                     r_fall_evt  <= 1'b1;
                     r_fall_seen <= 1'b1;
                  end else begin
                     r_state <= PEND_LOW;
                     r_cnt   <= CW'(1);
                  end
               end
               PEND_LOW: if (!w_lo_q) begin
                  r_state <= HIGH;
                  r_cnt   <= '0;
               end else if (w_cnt_inc == P_LAST) begin
                  r_state     <= LOW;
                  r_cnt       <= '0;
                  r_above     <= 1'b0;
                  r_fall_evt  <= 1'b1;
                  r_fall_seen <= 1'b1;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
               default: r_state <= LOW;
            endcase
         end
      end
   end

   assign greater   = r_greater;
   assign lesser    = r_lesser;
   assign equal     = r_equal;
   assign above     = r_above;
   assign rise_evt  = r_rise_evt;
   assign fall_evt  = r_fall_evt;
   assign rise_seen = r_rise_seen;
   assign fall_seen = r_fall_seen;
endmodule

// File: tb/tb_threshold_monitor.sv
// Scoreboard bench for threshold_monitor: the driver queues hand-computed output vectors
// {greater,lesser,equal,above,rise_evt,fall_evt,rise_seen,fall_seen}; a monitor compares them.
module tb_threshold_monitor;
   logic        clk = 1'b0;
   logic        s_rst, s_v, s_clr;
   logic [15:0] s_in, s_th, s_hy;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   logic [7:0]  act [3];
   logic        g0, l0, e0, a0, re0, fe0, rs0, fs0;
   logic        g1, l1, e1, a1, re1, fe1, rs1, fs1;
   logic        g2, l2, e2, a2, re2, fe2, rs2, fs2;

   typedef struct {
      int         due;
      int         id;
      logic [7:0] exp;
      string      nm;
   } exp_t;
   exp_t q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   threshold_monitor #(.WIDTH(16), .SIGNED(1'b0), .PERSIST(3)) dut0 (
      .clk(clk), .rst(s_rst), .in_valid(s_v), .in(s_in), .thresh(s_th), .hyst(s_hy), .clr(s_clr),
      .greater(g0), .lesser(l0), .equal(e0), .above(a0), .rise_evt(re0), .fall_evt(fe0),
      .rise_seen(rs0), .fall_seen(fs0));
   threshold_monitor #(.WIDTH(16), .SIGNED(1'b1), .PERSIST(3)) dut1 (
      .clk(clk), .rst(s_rst), .in_valid(s_v), .in(s_in), .thresh(s_th), .hyst(s_hy), .clr(s_clr),
      .greater(g1), .lesser(l1), .equal(e1), .above(a1), .rise_evt(re1), .fall_evt(fe1),
      .rise_seen(rs1), .fall_seen(fs1));
   threshold_monitor #(.WIDTH(16), .SIGNED(1'b0), .PERSIST(1)) dut2 (
      .clk(clk), .rst(s_rst), .in_valid(s_v), .in(s_in), .thresh(s_th), .hyst(s_hy), .clr(s_clr),
      .greater(g2), .lesser(l2), .equal(e2), .above(a2), .rise_evt(re2), .fall_evt(fe2),
      .rise_seen(rs2), .fall_seen(fs2));

   assign act[0] = {g0, l0, e0, a0, re0, fe0, rs0, fs0};
   assign act[1] = {g1, l1, e1, a1, re1, fe1, rs1, fs1};
   assign act[2] = {g2, l2, e2, a2, re2, fe2, rs2, fs2};

   // Monitor: each queued expectation is due one edge after its stimulus was applied.
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].due <= cyc) begin
         exp_t t;
         t = q.pop_front();
         checks++;
         if (t.due != cyc) begin
            errors++;
            $display("FAIL %s dut%0d stale expectation due %0d seen at %0d", t.nm, t.id, t.due, cyc);
         end else if (act[t.id] !== t.exp) begin
            errors++;
            $display("FAIL %s dut%0d got %b want %b", t.nm, t.id, act[t.id], t.exp);
         end else begin
            $display("ok   %s dut%0d = %b", t.nm, t.id, act[t.id]);
         end
      end
   end

   task automatic step(input logic r, input logic v, input logic [15:0] x, input logic [15:0] th,
                       input logic [15:0] hy, input logic c, input int id, input logic [7:0] e,
                       input string nm);
      exp_t t;
      s_rst = r; s_v = v; s_in = x; s_th = th; s_hy = hy; s_clr = c;
      t.due = cyc + 1; t.id = id; t.exp = e; t.nm = nm;
      q.push_back(t);
      @(posedge clk);
      #1;
   endtask

   localparam logic [7:0] Z  = 8'b0000_0000;
   localparam logic [7:0] GT = 8'b1000_0000;
   localparam logic [7:0] RS = 8'b1001_1010;

   initial begin
      s_rst = 1'b1; s_v = 1'b0; s_clr = 1'b0; s_in = '0; s_th = '0; s_hy = '0;
      @(posedge clk); #1;

      // Reset priority and clr without an event
      step(1, 1, 16'hFFFF, 16'd1000, 16'd50, 1, 0, Z, "rst_all_zero");
      step(0, 0, 16'd0, 16'd1000, 16'd50, 1, 0, Z, "clr_no_event");

      // Raw compare and hold
      step(1, 0, 16'd0, 16'd1000, 16'd50, 0, 0, Z, "rst_raw");
      step(0, 1, 16'd1000, 16'd1000, 16'd50, 0, 0, 8'b0010_0000, "raw_equal");
      step(0, 1, 16'd999, 16'd1000, 16'd50, 0, 0, 8'b0100_0000, "raw_lesser");
      step(0, 1, 16'd1001, 16'd1000, 16'd50, 0, 0, GT, "raw_greater");
      step(0, 0, 16'd0, 16'd1000, 16'd50, 0, 0, GT, "raw_hold1");
      step(0, 0, 16'd5000, 16'd1000, 16'd50, 0, 0, GT, "raw_hold2");

      // Three qualifying samples give a rise
      step(1, 0, 16'd0, 16'd1000, 16'd50, 0, 0, Z, "rst_p3");
      step(0, 1, 16'd1051, 16'd1000, 16'd50, 0, 0, GT, "p3_s1");
      step(0, 1, 16'd1051, 16'd1000, 16'd50, 0, 0, GT, "p3_s2");
      step(0, 1, 16'd1051, 16'd1000, 16'd50, 0, 0, RS, "p3_rise");
      step(0, 0, 16'd1051, 16'd1000, 16'd50, 0, 0, 8'b1001_0010, "p3_pulse_end");

      // Broken run returns to LOW and restarts the count
      step(1, 0, 16'd0, 16'd1000, 16'd50, 0, 0, Z, "rst_brk");
      step(0, 1, 16'd1051, 16'd1000, 16'd50, 0, 0, GT, "brk_s1");
      step(0, 1, 16'd1051, 16'd1000, 16'd50, 0, 0, GT, "brk_s2");
      step(0, 1, 16'd1040, 16'd1000, 16'd50, 0, 0, GT, "brk_break");
      step(0, 1, 16'd1051, 16'd1000, 16'd50, 0, 0, GT, "brk_no_rise");
      step(0, 1, 16'd1051, 16'd1000, 16'd50, 0, 0, GT, "brk_cnt2");
      step(0, 1, 16'd1051, 16'd1000, 16'd50, 0, 0, RS, "brk_rise");

      // Invalid gaps do not break a run
      step(1, 0, 16'd0, 16'd1000, 16'd50, 0, 0, Z, "rst_gap");
      step(0, 1, 16'd1051, 16'd1000, 16'd50, 0, 0, GT, "gap_s1");
      for (int i = 0; i < 4; i++)
         step(0, 0, 16'd0, 16'd1000, 16'd50, 0, 0, GT, "gap_idle");
      step(0, 1, 16'd1051, 16'd1000, 16'd50, 0, 0, GT, "gap_s2");
      step(0, 1, 16'd1051, 16'd1000, 16'd50, 0, 0, RS, "gap_rise");

      // Hysteresis, fall and clr colliding with the fall pulse
      step(0, 0, 16'd0, 16'd1000, 16'd50, 0, 0, 8'b1001_0010, "hy_idle");
      for (int i = 0; i < 3; i++)
         step(0, 1, 16'd960, 16'd1000, 16'd50, 0, 0, 8'b0101_0010, "hy_in_band");
      step(0, 1, 16'd949, 16'd1000, 16'd50, 0, 0, 8'b0101_0010, "hy_lo1");
      step(0, 1, 16'd949, 16'd1000, 16'd50, 0, 0, 8'b0101_0010, "hy_lo2");
      step(0, 1, 16'd949, 16'd1000, 16'd50, 0, 0, 8'b0100_0111, "hy_fall");
      step(0, 0, 16'd0, 16'd1000, 16'd50, 1, 0, 8'b0100_0001, "clr_vs_fall");
      step(0, 0, 16'd0, 16'd1000, 16'd50, 1, 0, 8'b0100_0000, "clr_after");

      // Signed mode
      step(1, 0, 16'd0, 16'hFFF6, 16'd5, 0, 1, Z, "rst_sgn");
      step(0, 1, 16'hFFFC, 16'hFFF6, 16'd5, 0, 1, GT, "sgn_s1");
      step(0, 1, 16'hFFFC, 16'hFFF6, 16'd5, 0, 1, GT, "sgn_s2");
      step(0, 1, 16'hFFFC, 16'hFFF6, 16'd5, 0, 1, RS, "sgn_rise");
      step(1, 0, 16'd0, 16'hFFF6, 16'd5, 0, 1, Z, "rst_sgn2");
      step(0, 1, 16'h0003, 16'hFFF6, 16'd5, 0, 1, GT, "sgnpos_s1");
      step(0, 1, 16'h0003, 16'hFFF6, 16'd5, 0, 1, GT, "sgnpos_s2");
      step(0, 1, 16'h0003, 16'hFFF6, 16'd5, 0, 1, RS, "sgnpos_rise");

      // Unreachable upper trip point
      step(1, 0, 16'd0, 16'hFFF0, 16'h0020, 0, 0, Z, "rst_range");
      for (int i = 0; i < 5; i++)
         step(0, 1, 16'hFFFF, 16'hFFF0, 16'h0020, 0, 0, GT, "range_no_rise");

      // Reset mid-pending discards the count
      step(1, 0, 16'd0, 16'd1000, 16'd50, 0, 0, Z, "rst_mid");
      step(0, 1, 16'd1051, 16'd1000, 16'd50, 0, 0, GT, "mid_s1");
      step(0, 1, 16'd1051, 16'd1000, 16'd50, 0, 0, GT, "mid_s2");
      step(1, 1, 16'd1051, 16'd1000, 16'd50, 0, 0, Z, "mid_rst");
      step(0, 1, 16'd1051, 16'd1000, 16'd50, 0, 0, GT, "mid_cnt1");
      step(0, 1, 16'd1051, 16'd1000, 16'd50, 0, 0, GT, "mid_cnt2");
      step(0, 1, 16'd1051, 16'd1000, 16'd50, 0, 0, RS, "mid_rise");

      // PERSIST=1 instance
      step(1, 0, 16'd0, 16'd1000, 16'd50, 0, 2, Z, "rst_p1");
      step(0, 1, 16'd1051, 16'd1000, 16'd50, 0, 2, RS, "p1_rise");
      step(0, 1, 16'd949, 16'd1000, 16'd50, 0, 2, 8'b0100_0111, "p1_fall");
      step(0, 1, 16'd1051, 16'd1000, 16'd50, 1, 2, 8'b1001_1011, "p1_clr_vs_evt");
      step(0, 0, 16'd0, 16'd1000, 16'd50, 1, 2, 8'b1001_0010, "p1_clr_after");

      s_v = 1'b0; s_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain pending %0d want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout cycle %0d", cyc);
      $fatal(1, "timeout");
   end
endmodule
